// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared ALU operand width and opcode definitions
package alu_pkg;

  localparam int OPND_W = 8;
  localparam int OP_W   = 2;
  localparam int RES_W  = OPND_W + 1;

  typedef enum logic [OP_W-1:0] {
    OP_ADD = 2'd0,
    OP_SUB = 2'd1,
    OP_AND = 2'd2,
    OP_OR  = 2'd3
  } alu_op_e;

endpackage

// File: rtl/alu_cmd_issuer_if.sv
// rtl/alu_cmd_issuer_if.sv - command, ALU and result signals of the command issuer
interface alu_cmd_issuer_if #(
  parameter int DEPTH = 4,
  parameter int TAG_W = 4
);
  import alu_pkg::*;

  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic              in_valid;
  logic              in_ready;
  logic [OPND_W-1:0] in_a;
  logic [OPND_W-1:0] in_b;
  logic [OP_W-1:0]   in_op;
  logic [TAG_W-1:0]  in_tag;
  logic              issue_en;
  logic [OPND_W-1:0] alu_a;
  logic [OPND_W-1:0] alu_b;
  logic [OP_W-1:0]   alu_op;
  logic [OPND_W-1:0] alu_res;
  logic              alu_carry;
  logic              res_valid;
  logic [RES_W-1:0]  res_data;
  logic [TAG_W-1:0]  res_tag;
  logic [CNT_W-1:0]  count;

  modport master (
    output in_valid, in_a, in_b, in_op, in_tag, issue_en, alu_res, alu_carry,
    input  in_ready, alu_a, alu_b, alu_op, res_valid, res_data, res_tag, count
  );

  modport slave (
    input  in_valid, in_a, in_b, in_op, in_tag, issue_en, alu_res, alu_carry,
    output in_ready, alu_a, alu_b, alu_op, res_valid, res_data, res_tag, count
  );

endinterface

// File: rtl/cmd_fifo.sv
// rtl/cmd_fifo.sv - circular command store with occupancy count
module cmd_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 22
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   i_push,
  input  logic [W-1:0]           i_data,
  input  logic                   i_pop,
  output logic [W-1:0]           o_data,
  output logic [$clog2(DEPTH):0] o_count
);
  localparam int PTR_W = $clog2(DEPTH);

  logic [W-1:0]     r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [PTR_W:0]   r_count;

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (i_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (i_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      case ({i_push, i_pop})
        2'b10:   r_count <= r_count + (PTR_W+1)'(1);
        2'b01:   r_count <= r_count - (PTR_W+1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (i_push && !rst) r_mem[r_wr_ptr] <= i_data;
  end

  assign o_data  = r_mem[r_rd_ptr];
  assign o_count = r_count;

endmodule

// File: rtl/alu_cmd_issuer.sv
// rtl/alu_cmd_issuer.sv - queues ALU commands, issues them in order and tags the registered results
module alu_cmd_issuer
  import alu_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int TAG_W = 4
) (
  input logic            clk,
  input logic            rst,
  alu_cmd_issuer_if.slave bus
);
  localparam int PAY_W = 2*OPND_W + OP_W + TAG_W;
  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic              w_accept;
  logic              w_issue;
  logic [PAY_W-1:0]  w_head;
  logic [CNT_W-1:0]  w_count;
  logic [OPND_W-1:0] w_head_a;
  logic [OPND_W-1:0] w_head_b;
  logic [OP_W-1:0]   w_head_op;
  logic [TAG_W-1:0]  w_head_tag;
  logic              r_issued_q;
  logic [TAG_W-1:0]  r_tag_q;

  // in_ready comes from the registered count only, so a same-cycle issue never frees a slot early.
  assign bus.in_ready = (w_count < CNT_W'(DEPTH));
  assign w_accept     = bus.in_valid && bus.in_ready && !rst;
  assign w_issue      = (w_count != '0) && bus.issue_en && !rst;

  cmd_fifo #(
    .DEPTH (DEPTH),
    .W     (PAY_W)
  ) u_cmd_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (w_accept),
    .i_data  ({bus.in_tag, bus.in_op, bus.in_b, bus.in_a}),
    .i_pop   (w_issue),
    .o_data  (w_head),
    .o_count (w_count)
  );

  assign w_head_a   = w_head[OPND_W-1:0];
  assign w_head_b   = w_head[2*OPND_W-1:OPND_W];
  assign w_head_op  = w_head[2*OPND_W+OP_W-1:2*OPND_W];
  assign w_head_tag = w_head[PAY_W-1:2*OPND_W+OP_W];

  assign bus.alu_a  = w_issue ? w_head_a  : '0;
  assign bus.alu_b  = w_issue ? w_head_b  : '0;
  assign bus.alu_op = w_issue ? w_head_op : '0;

  // Mirrors the ALU's one-cycle output register so the tag lines up with its result.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_issued_q <= 1'b0;
      r_tag_q    <= '0;
    end else begin
      r_issued_q <= w_issue;
      if (w_issue) r_tag_q <= w_head_tag;
    end
  end

  assign bus.res_valid = r_issued_q;
  assign bus.res_tag   = r_tag_q;
  assign bus.res_data  = {bus.alu_carry, bus.alu_res};
  assign bus.count     = w_count;

endmodule

// File: tb/tb_alu_cmd_issuer.sv
// tb/tb_alu_cmd_issuer.sv - bench for alu_cmd_issuer with a stand-in ALU and a queue-based reference
module tb_alu_cmd_issuer;
  localparam int DEPTH = 4;
  localparam int TAG_W = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  alu_cmd_issuer_if #(.DEPTH(DEPTH), .TAG_W(TAG_W)) bus ();

  alu_cmd_issuer #(.DEPTH(DEPTH), .TAG_W(TAG_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  function automatic logic [8:0] alu_ref(input logic [7:0] a, input logic [7:0] b, input logic [1:0] op);
    case (op)
      2'd0:    return {1'b0, a} + {1'b0, b};
      2'd1:    return {1'b0, a} - {1'b0, b};
      2'd2:    return {1'b0, a & b};
      default: return {1'b0, a | b};
    endcase
  endfunction

  // Downstream ALU: registers its result one cycle after the operands.
  logic [8:0] r_alu_q;
  always_ff @(posedge clk) r_alu_q <= alu_ref(bus.alu_a, bus.alu_b, bus.alu_op);
  assign bus.alu_res   = r_alu_q[7:0];
  assign bus.alu_carry = r_alu_q[8];

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic [1:0] op;
    logic [3:0] tag;
  } cmd_t;

  typedef struct {
    bit         r;
    bit         iv;
    cmd_t       c;
    bit         ie;
    bit         e_rdy;
    int         e_cnt;
    bit         e_rv;
    logic [8:0] e_rd;
    logic [3:0] e_rt;
    bit         ct;
  } vec_t;

  cmd_t       mq[$];
  bit         m_pv = 1'b0;
  logic [8:0] m_pd = '0;
  logic [3:0] m_pt = '0;
  int         checks = 0;
  int         errors = 0;
  int         obs_tags[$];
  bit         cur_rst, cur_iv, cur_ie;
  cmd_t       cur_cmd;
  vec_t       tbl[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive_sample(input bit r, input bit iv, input cmd_t c, input bit ie);
    bit   iss;
    cmd_t h;
    cur_rst = r; cur_iv = iv; cur_cmd = c; cur_ie = ie;
    rst = r;
    bus.in_valid = iv;
    bus.in_a = c.a; bus.in_b = c.b; bus.in_op = c.op; bus.in_tag = c.tag;
    bus.issue_en = ie;
    #2;
    iss = !r && (mq.size() > 0) && ie;
    h = '{a: 8'h0, b: 8'h0, op: 2'd0, tag: 4'd0};
    if (iss) h = mq[0];
    chk("in_ready", 32'(bus.in_ready), 32'(mq.size() < DEPTH));
    chk("count", 32'(bus.count), 32'(mq.size()));
    chk("alu_a", 32'(bus.alu_a), 32'(h.a));
    chk("alu_b", 32'(bus.alu_b), 32'(h.b));
    chk("alu_op", 32'(bus.alu_op), 32'(h.op));
    chk("res_valid", 32'(bus.res_valid), 32'(m_pv));
    if (m_pv) begin
      chk("res_data", 32'(bus.res_data), 32'(m_pd));
      chk("res_tag", 32'(bus.res_tag), 32'(m_pt));
    end
    if (bus.res_valid === 1'b1) obs_tags.push_back(int'(bus.res_tag));
  endtask

  task automatic finish_cycle();
    bit iss, acc;
    iss = !cur_rst && (mq.size() > 0) && cur_ie;
    acc = !cur_rst && cur_iv && (mq.size() < DEPTH);
    @(posedge clk);
    #1;
    if (cur_rst) begin
      mq.delete();
      m_pv = 1'b0;
    end else begin
      m_pv = iss;
      if (iss) begin
        m_pd = alu_ref(mq[0].a, mq[0].b, mq[0].op);
        m_pt = mq[0].tag;
        void'(mq.pop_front());
      end
      if (acc) mq.push_back(cur_cmd);
    end
  endtask

  function automatic cmd_t mk(input int a, input int b, input int op, input int tag);
    cmd_t c;
    c.a = 8'(a); c.b = 8'(b); c.op = 2'(op); c.tag = 4'(tag);
    return c;
  endfunction

  function automatic vec_t v(input bit r, input bit iv, input cmd_t c, input bit ie, input bit rdy,
                             input int cnt, input bit rv, input int rd, input int rt, input bit ct);
    vec_t x;
    x.r = r; x.iv = iv; x.c = c; x.ie = ie; x.e_rdy = rdy; x.e_cnt = cnt;
    x.e_rv = rv; x.e_rd = 9'(rd); x.e_rt = 4'(rt); x.ct = ct;
    return x;
  endfunction

  function automatic vec_t idle(input bit ie, input bit rdy, input int cnt, input bit rv, input int rd, input int rt);
    return v(1'b0, 1'b0, mk(0, 0, 0, 0), ie, rdy, cnt, rv, rd, rt, 1'b0);
  endfunction

  initial begin
    bus.in_valid = 1'b0; bus.in_a = '0; bus.in_b = '0; bus.in_op = '0; bus.in_tag = '0; bus.issue_en = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    drive_sample(1'b1, 1'b0, mk(0, 0, 0, 0), 1'b0);
    chk("reset_res_tag", 32'(bus.res_tag), 32'd0);
    finish_cycle();

    // Single command, then SUB borrow and logic ops.
    tbl.push_back(v(0, 1, mk('hF0, 'h20, 0, 3), 1, 1, 0, 0, 0, 0, 0));
    tbl.push_back(idle(1, 1, 1, 0, 0, 0));
    tbl.push_back(idle(1, 1, 0, 1, 'h110, 3));
    tbl.push_back(idle(1, 1, 0, 0, 0, 0));
    tbl.push_back(v(0, 1, mk('h05, 'h06, 1, 1), 1, 1, 0, 0, 0, 0, 0));
    tbl.push_back(v(0, 1, mk('hFF, 'h0F, 2, 2), 1, 1, 1, 0, 0, 0, 0));
    tbl.push_back(v(0, 1, mk('hFF, 'h0F, 3, 4), 1, 1, 1, 1, 'h1FF, 1, 0));
    tbl.push_back(idle(1, 1, 1, 1, 'h00F, 2));
    tbl.push_back(idle(1, 1, 0, 1, 'h0FF, 4));
    tbl.push_back(idle(1, 1, 0, 0, 0, 0));
    // Fill while paused: fifth offer refused, then drain in order.
    for (int i = 0; i < 5; i++)
      tbl.push_back(v(0, 1, mk(i + 1, 1, 0, i), 0, (i < 4), i, 0, 0, 0, 0));
    tbl.push_back(idle(1, 0, 4, 0, 0, 0));
    for (int j = 0; j < 4; j++)
      tbl.push_back(idle(1, 1, 3 - j, 1, j + 2, j));
    tbl.push_back(idle(1, 1, 0, 0, 0, 0));
    // Full FIFO with simultaneous offer and issue.
    for (int i = 0; i < 4; i++)
      tbl.push_back(v(0, 1, mk('h10 + i, 0, 3, 5 + i), 0, 1, i, 0, 0, 0, 0));
    tbl.push_back(v(0, 1, mk('h20, 0, 0, 9), 1, 0, 4, 0, 0, 0, 0));
    tbl.push_back(v(0, 1, mk('h20, 0, 0, 9), 1, 1, 3, 1, 'h010, 5, 0));
    tbl.push_back(idle(1, 1, 3, 1, 'h011, 6));
    tbl.push_back(idle(0, 1, 2, 1, 'h012, 7));
    tbl.push_back(idle(0, 1, 2, 0, 0, 0));
    tbl.push_back(idle(1, 1, 2, 0, 0, 0));
    tbl.push_back(idle(1, 1, 1, 1, 'h013, 8));
    tbl.push_back(idle(1, 1, 0, 1, 'h020, 9));
    tbl.push_back(idle(1, 1, 0, 0, 0, 0));
    // Reset while an issue is pending with two entries queued.
    tbl.push_back(v(0, 1, mk(1, 0, 0, 10), 0, 1, 0, 0, 0, 0, 0));
    tbl.push_back(v(0, 1, mk(2, 0, 0, 11), 0, 1, 1, 0, 0, 0, 0));
    tbl.push_back(v(0, 1, mk(3, 0, 0, 12), 0, 1, 2, 0, 0, 0, 0));
    tbl.push_back(idle(1, 1, 3, 0, 0, 0));
    tbl.push_back(v(1, 1, mk(7, 7, 0, 13), 1, 1, 2, 1, 'h001, 10, 0));
    tbl.push_back(v(0, 0, mk(0, 0, 0, 0), 1, 1, 0, 0, 0, 0, 1));
    tbl.push_back(idle(1, 1, 0, 0, 0, 0));
    tbl.push_back(idle(1, 1, 0, 0, 0, 0));
    tbl.push_back(v(0, 1, mk('h80, 'h80, 0, 7), 1, 1, 0, 0, 0, 0, 0));
    tbl.push_back(idle(1, 1, 1, 0, 0, 0));
    tbl.push_back(idle(1, 1, 0, 1, 'h100, 7));

    foreach (tbl[i]) begin
      drive_sample(tbl[i].r, tbl[i].iv, tbl[i].c, tbl[i].ie);
      chk($sformatf("row%0d_in_ready", i), 32'(bus.in_ready), 32'(tbl[i].e_rdy));
      chk($sformatf("row%0d_count", i), 32'(bus.count), 32'(tbl[i].e_cnt));
      chk($sformatf("row%0d_res_valid", i), 32'(bus.res_valid), 32'(tbl[i].e_rv));
      if (tbl[i].e_rv) chk($sformatf("row%0d_res_data", i), 32'(bus.res_data), 32'(tbl[i].e_rd));
      if (tbl[i].e_rv || tbl[i].ct) chk($sformatf("row%0d_res_tag", i), 32'(bus.res_tag), 32'(tbl[i].e_rt));
      finish_cycle();
    end

    // Twelve back-to-back commands walk the pointers around several times.
    obs_tags.delete();
    for (int i = 0; i < 12; i++) begin
      drive_sample(1'b0, 1'b1, mk(i, 3 * i, i % 4, i), 1'b1);
      finish_cycle();
    end
    for (int i = 0; i < 4; i++) begin
      drive_sample(1'b0, 1'b0, mk(0, 0, 0, 0), 1'b1);
      finish_cycle();
    end
    chk("wrap_result_count", 32'(obs_tags.size()), 32'd12);
    foreach (obs_tags[i]) chk($sformatf("wrap_tag%0d", i), 32'(obs_tags[i]), 32'(i % 16));

    for (int n = 0; n < 2000; n++) begin
      drive_sample(($urandom_range(0, 99) == 0), ($urandom_range(0, 3) != 0),
                   mk($urandom_range(0, 255), $urandom_range(0, 255), $urandom_range(0, 3), $urandom_range(0, 15)),
                   ($urandom_range(0, 99) < 60));
      finish_cycle();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/alu_cmd_issuer.md
ALU_CMD_ISSUER -- requirements
Module: alu_cmd_issuer

Interface
REQ-001 The block SHALL have parameter DEPTH, default 4, command FIFO entries (power of two, 2..16).
REQ-002 The block SHALL have parameter TAG_W, default 4, command tag width.
REQ-003 The block SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-005 The block SHALL have port in_valid  input  1  command offered.
REQ-006 The block SHALL have port in_ready  output  1  command slot free.
REQ-007 The block SHALL have ports in_a, in_b  input  8 each  operands.
REQ-008 The block SHALL have port in_op  input  2  opcode: 0 ADD, 1 SUB, 2 AND, 3 OR.
REQ-009 The block SHALL have port in_tag  input  TAG_W  caller tag.
REQ-010 The block SHALL have port issue_en  input  1  issue permission; low pauses issue.
REQ-011 The block SHALL have ports alu_a, alu_b  output  8 each, and alu_op  output  2, driven to the downstream ALU.
REQ-012 The block SHALL have ports alu_res  input  8 and alu_carry  input  1, taken from the ALU registered outputs.
REQ-013 The block SHALL have port res_valid  output  1  result qualifier.
REQ-014 The block SHALL have port res_data  output  9  {alu_carry, alu_res}.
REQ-015 The block SHALL have port res_tag  output  TAG_W  tag of the command whose result is on res_data.
REQ-016 The block SHALL have port count  output  $clog2(DEPTH)+1  FIFO occupancy.

Function
REQ-017 The block SHALL accept a command at a rising edge where in_valid && in_ready.
REQ-018 The block SHALL drive in_ready = (count < DEPTH), derived from registered state only, independent of the same-cycle issue.
REQ-019 The block SHALL issue the FIFO head in any cycle where count > 0 && issue_en, driving alu_a/alu_b/alu_op from the head entry, and SHALL pop it at that edge.
REQ-020 The block SHALL drive alu_a, alu_b and alu_op to 0 in cycles with no issue.
REQ-021 The block SHALL NOT bypass: a command accepted at edge k issues no earlier than the cycle following edge k.
REQ-022 The block SHALL delay issue by one registered stage (issued_q, tag_q), so that res_valid = issued_q and res_tag = tag_q; res_valid is high in the cycle after the issue cycle, matching the ALU's one-cycle register.
REQ-023 The block SHALL drive res_data combinationally as {alu_carry, alu_res}, meaningful only while res_valid is high.
REQ-024 On simultaneous accept and issue, count SHALL stay unchanged; on a full FIFO the issue frees a slot visible the next cycle.
REQ-025 Read and write pointers SHALL wrap modulo DEPTH; commands SHALL issue in strict acceptance order.
REQ-026 Throughput SHALL be one command per cycle sustained while issue_en is high.
REQ-027 With issue_en low, entries SHALL be held, res_valid SHALL drop the next cycle, and accepts SHALL continue until full.

Reset
REQ-028 While rst is high at an edge, pointers and count SHALL go to 0, issued_q and tag_q to 0, and any FIFO contents SHALL be discarded; the output values are therefore in_ready=1, res_valid=0, res_tag=0, count=0, and alu_a/alu_b/alu_op=0.
REQ-029 A reset mid-operation SHALL drop in-flight results: res_valid SHALL be 0 in the cycle after reset, even if an issue occurred in the reset cycle.
REQ-030 No command SHALL be accepted or issued in a cycle where rst is high.

Structure
REQ-031 Opcode constants (OP_ADD..OP_OR) and the operand width SHALL live in shared package alu_pkg, which the ALU also uses.
REQ-032 FIFO storage and pointers SHALL be one sub-module, cmd_fifo (parameterised DEPTH, payload width 18+TAG_W); the issue and result-tracking logic stays in alu_cmd_issuer.

Verification
REQ-033 Single command: push A=8'hF0, B=8'h20, op=0, tag=3 with issue_en=1 -> issue the next cycle, then res_valid=1, res_data=9'h110, res_tag=3 two cycles after acceptance.
REQ-034 Fill and pause: issue_en=0 with 5 offered commands -> 4 accepted, count=4, in_ready=0; raise issue_en -> four results in order on consecutive cycles, with tags 0,1,2,3.
REQ-035 Full plus simultaneous push/pop: count=4, issue_en=1, in_valid=1 -> no accept that cycle, count=3 the next cycle, then accept.
REQ-036 SUB borrow and logic ops: A=8'h05, B=8'h06, op=1 -> res_data=9'h1FF; A=8'hFF, B=8'h0F, op=2 -> 9'h00F; op=3 -> 9'h0FF.
REQ-037 Reset mid-stream: rst asserted in the cycle a command issues, with 2 entries queued -> res_valid=0, count=0, in_ready=1 after reset, and no stale result appears afterwards.
REQ-038 Wrap: 12 back-to-back commands with incrementing tags -> res_tag sequence 0..11, no gaps or duplicates.
